// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Write side of the byte-addressed instruction memory. A byte stream arrives
// over a valid/ready handshake. Every four bytes are packed into one 32-bit
// word, most significant byte first, because the fetch path reads the memory
// as big-endian words. Each finished word is written through a single-cycle
// write port. Words go to consecutive 4-aligned addresses, starting at a base
// address that is programmed with the request. The loader owns the memory
// port only while busy is high.
//
// Parameters
//   DEPTH_BYTES : size of the target memory in bytes; legal range [0, DEPTH_BYTES)
//   LEN_W       : width of the word-count input
//
// Ports
//   clk        in   1     rising-edge clock
//   reset_n    in   1     asynchronous active-low reset
//   start      in   1     one-cycle load request, sampled only while idle
//   base_addr  in   64    byte address of the first word (latched on start)
//   len_words  in   LEN_W number of words to load (latched on start)
//   in_byte    in   8     stream byte
//   in_valid   in   1     stream byte valid
//   in_ready   out  1     loader takes a byte this cycle
//   wr_en      out  1     memory write strobe, one cycle per word
//   wr_addr    out  64    word byte address (always 4-aligned)
//   wr_data    out  32    packed word, first byte of the group in [31:24]
//   busy       out  1     loader owns the memory
//   done       out  1     one-cycle pulse, load completed
//   err        out  1     one-cycle pulse, request rejected
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LEN_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [63:0]      base_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [63:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;

  // Request latched on an accepted start
  logic [63:0]      base_r;
  logic [LEN_W-1:0] len_r;

  // Progress through the request
  logic [LEN_W-1:0] idx_r;      // index of the word currently being assembled
  logic [1:0]       cnt_r;      // bytes already held in word_r (mod 4)
  logic [31:0]      word_r;     // assembly register, shifts left by a byte per handshake

  // Registered outputs
  logic             in_ready_r;
  logic             wr_en_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic [63:0]      wr_addr_r;
  logic [31:0]      wr_data_r;

  // Combinational helpers
  logic [65:0]      end_addr_s;
  logic             bad_req_s;
  logic             hs_s;
  logic             last_byte_s;
  logic             last_word_s;
  logic [31:0]      next_word_s;
  logic [LEN_W-1:0] idx_inc_s;
  logic [63:0]      word_addr_s;

  // Legality of the incoming request.
  // The end address is formed at 66 bits, so a base near the top of the 64-bit
  // space cannot wrap around and slip under the limit.
  always_comb begin
    end_addr_s = {2'b00, base_addr} + {{(64-LEN_W){1'b0}}, len_words, 2'b00};
    bad_req_s  = (base_addr[1:0] != 2'b00) || (end_addr_s > 66'(DEPTH_BYTES));
  end

  // Stream handshake and word-assembly helpers.
  // The handshake uses the registered ready, so there is no combinational path
  // from in_valid to in_ready.
  always_comb begin
    hs_s        = in_valid & in_ready_r;
    next_word_s = {word_r[23:0], in_byte};
    last_byte_s = hs_s && (cnt_r == 2'd3);
    idx_inc_s   = idx_r + LEN_W'(1);
    // idx_r never exceeds len_r - 1, so idx_r + 1 cannot wrap.
    last_word_s = (idx_inc_s == len_r);
    word_addr_s = base_r + {{(62-LEN_W){1'b0}}, idx_r, 2'b00};
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (bad_req_s) begin
            state_s = ST_ERR;
          end else if (len_words == {LEN_W{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (last_byte_s) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (last_word_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      ST_ERR:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Output flags, registered from the next state so they line up with the state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_r <= 1'b0;
      wr_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      in_ready_r <= (state_s == ST_LOAD);
      wr_en_r    <= (state_s == ST_WRITE);
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= (state_s == ST_DONE);
      err_r      <= (state_s == ST_ERR);
    end
  end

  // Request capture, byte assembly and word indexing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_r <= 64'd0;
      len_r  <= {LEN_W{1'b0}};
      idx_r  <= {LEN_W{1'b0}};
      cnt_r  <= 2'd0;
      word_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            base_r <= base_addr;
            len_r  <= len_words;
            idx_r  <= {LEN_W{1'b0}};
            cnt_r  <= 2'd0;
            word_r <= 32'd0;
          end
        end
        ST_LOAD: begin
          if (hs_s) begin
            word_r <= next_word_s;
            cnt_r  <= cnt_r + 2'd1;
          end
        end
        ST_WRITE: begin
          if (!last_word_s) begin
            idx_r <= idx_inc_s;
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  // Write-port address/data.
  // These are loaded together with the fourth byte, so they are already stable
  // during the WRITE cycle. They hold their value at all other times.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr_r <= 64'd0;
      wr_data_r <= 32'd0;
    end else if (last_byte_s) begin
      wr_addr_r <= word_addr_s;
      wr_data_r <= next_word_s;
    end else begin
      wr_addr_r <= wr_addr_r;
      wr_data_r <= wr_data_r;
    end
  end

  assign in_ready = in_ready_r;
  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized loads
// checked against a word-level reference model.
module tb_imem_loader;
  localparam int LEN_W = 16;
  localparam int DEPTH = 1024;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [63:0]      base_addr = 64'd0;
  logic [LEN_W-1:0] len_words = 16'd0;
  logic [7:0]       in_byte = 8'd0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             wr_en;
  logic [63:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             busy;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_BYTES(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .len_words(len_words), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Observed activity (monitor only appends; tests take snapshots)
  logic [63:0] mon_addr_q[$];
  logic [31:0] mon_data_q[$];
  int          mon_cyc_q[$];
  int done_cnt = 0, err_cnt = 0, ir_cnt = 0, ir_in_wr = 0;
  int done_cyc = 0, last_busy_cyc = 0;
  int hs_q[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_en) begin
        mon_addr_q.push_back(wr_addr);
        mon_data_q.push_back(wr_data);
        mon_cyc_q.push_back(cyc);
        if (in_ready) ir_in_wr = ir_in_wr + 1;
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (err) err_cnt = err_cnt + 1;
      if (in_ready) ir_cnt = ir_cnt + 1;
      if (busy) last_busy_cyc = cyc;
    end
  end

  // ---------------- drivers and reference model ----------------
  task automatic do_start(input logic [63:0] b, input logic [15:0] l);
    start = 1'b1;
    base_addr = b;
    len_words = l;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = {$urandom, $urandom};   // scramble: the request must already be latched
    len_words = 16'($urandom);
  endtask

  // mode 0: valid every cycle, 1: valid toggles 1/0, 2: random valid
  task automatic send_bytes(input logic [7:0] bq[$], input int mode, output bit ok);
    int i = 0;
    bit tog = 1'b1;
    ok = 1'b0;
    hs_q.delete();
    for (int c = 0; c < 400; c++) begin
      case (mode)
        0: in_valid = 1'b1;
        1: begin in_valid = tog; tog = ~tog; end
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_byte = bq[i];
      @(negedge clk);
      if (in_valid && in_ready) begin
        hs_q.push_back(cyc);
        i++;
      end
      @(posedge clk); #1;
      if (i == bq.size()) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_byte = 8'($urandom);
  endtask

  // Bounded wait for the loader to go idle; recover with a reset on timeout.
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  // Word-level model: legality from plain arithmetic, then word w goes to
  // base + 4w and carries bytes 4w..4w+3, first byte most significant.
  task automatic model(input logic [63:0] b, input int l, input logic [7:0] bq[$],
                       output bit legal, output logic [63:0] ea[$], output logic [31:0] ed[$]);
    logic [65:0] end_a;
    end_a = 66'(b) + 66'(l) * 66'd4;
    legal = (b[1:0] == 2'b00) && (end_a <= 66'(DEPTH));
    ea.delete();
    ed.delete();
    if (legal) begin
      for (int w = 0; w < l; w++) begin
        ea.push_back(b + 64'(4 * w));
        ed.push_back({bq[4*w], bq[4*w+1], bq[4*w+2], bq[4*w+3]});
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] bq[$];
    bit ok;
    int n0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({in_ready, wr_en, busy, done, err, wr_addr, wr_data} !== 101'd0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", {in_ready, wr_en, busy, done, err, wr_addr, wr_data});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Mid-load reset: one full word plus two bytes of the next
    n0 = mon_addr_q.size();
    do_start(64'd0, 16'd2);
    for (int k = 0; k < 6; k++) bq.push_back(8'($urandom));
    send_bytes(bq, 0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL reset_send timeout got=0 exp=1"); end
    total++;
    if (mon_addr_q.size() - n0 !== 1) begin
      bad++;
      $display("FAIL reset_prewrites got=%0d exp=1", mon_addr_q.size() - n0);
    end else begin
      total++;
      if ({mon_addr_q[n0], mon_data_q[n0]} !== {64'd0, bq[0], bq[1], bq[2], bq[3]}) begin
        bad++;
        $display("FAIL reset_preword got=%h@%h exp=%h@0", mon_data_q[n0], mon_addr_q[n0],
                 {bq[0], bq[1], bq[2], bq[3]});
      end
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({in_ready, wr_en, busy, done, err, wr_addr, wr_data} !== 101'd0) begin
      bad++;
      $display("FAIL reset_midload got=%h exp=0", {in_ready, wr_en, busy, done, err, wr_addr, wr_data});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_norestart busy got=%b exp=0", busy); end

    n0 = mon_addr_q.size();
    do_start(64'd0, 16'd1);
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_bytes(bq, 0, ok);
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL reset_reload idle timeout got=0 exp=1"); end
    total++;
    if (mon_addr_q.size() - n0 !== 1) begin
      bad++;
      $display("FAIL reset_reload_count got=%0d exp=1", mon_addr_q.size() - n0);
    end else begin
      total++;
      if ({mon_addr_q[n0], mon_data_q[n0]} !== {64'd0, 32'h11223344}) begin
        bad++;
        $display("FAIL reset_reload_word got=%h@%h exp=11223344@0", mon_data_q[n0], mon_addr_q[n0]);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] bq[$];
    bit ok;
    int n0, d0, w0;
    n0 = mon_addr_q.size();
    d0 = done_cnt;
    w0 = ir_in_wr;
    bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    do_start(64'h10, 16'd2);
    total++;
    if ({busy, in_ready} !== 2'b11) begin
      bad++;
      $display("FAIL basic_t1 busy,in_ready got=%b exp=11", {busy, in_ready});
    end
    send_bytes(bq, 0, ok);
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic idle timeout got=0 exp=1"); end
    total++;
    if (mon_addr_q.size() - n0 !== 2) begin
      bad++;
      $display("FAIL basic_count got=%0d exp=2", mon_addr_q.size() - n0);
    end else begin
      total++;
      if ({mon_addr_q[n0], mon_data_q[n0], mon_addr_q[n0+1], mon_data_q[n0+1]} !==
          {64'h10, 32'hDEADBEEF, 64'h14, 32'h01020304}) begin
        bad++;
        $display("FAIL basic_words got=%h@%h %h@%h exp=deadbeef@10 01020304@14",
                 mon_data_q[n0], mon_addr_q[n0], mon_data_q[n0+1], mon_addr_q[n0+1]);
      end
      total++;
      if (mon_cyc_q[n0] !== hs_q[3] + 1) begin
        bad++;
        $display("FAIL basic_wr_latency got=%0d exp=%0d", mon_cyc_q[n0], hs_q[3] + 1);
      end
      total++;
      if (mon_cyc_q[n0+1] - mon_cyc_q[n0] !== 5) begin
        bad++;
        $display("FAIL basic_throughput got=%0d exp=5", mon_cyc_q[n0+1] - mon_cyc_q[n0]);
      end
      total++;
      if (done_cyc !== mon_cyc_q[n0+1] + 1) begin
        bad++;
        $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cyc, mon_cyc_q[n0+1] + 1);
      end
    end
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0); end
    total++;
    if (ir_in_wr - w0 !== 0) begin bad++; $display("FAIL basic_ready_in_write got=%0d exp=0", ir_in_wr - w0); end
    total++;
    if (last_busy_cyc !== done_cyc) begin
      bad++;
      $display("FAIL basic_busy_end got=%0d exp=%0d", last_busy_cyc, done_cyc);
    end
  endtask

  task automatic test_stall();
    logic [7:0] bq[$];
    bit ok;
    int n0;
    n0 = mon_addr_q.size();
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_start(64'd0, 16'd1);
    send_bytes(bq, 1, ok);
    wait_idle(ok);
    total++;
    if (hs_q.size() !== 4) begin bad++; $display("FAIL stall_handshakes got=%0d exp=4", hs_q.size()); end
    total++;
    if (mon_addr_q.size() - n0 !== 1) begin
      bad++;
      $display("FAIL stall_count got=%0d exp=1", mon_addr_q.size() - n0);
    end else begin
      total++;
      if ({mon_addr_q[n0], mon_data_q[n0]} !== {64'd0, 32'h11223344}) begin
        bad++;
        $display("FAIL stall_word got=%h@%h exp=11223344@0", mon_data_q[n0], mon_addr_q[n0]);
      end
    end
  endtask

  task automatic test_bounds();
    logic [63:0] bases[4] = '{64'd1020, 64'd1020, 64'h2, 64'hFFFF_FFFF_FFFF_FFFC};
    logic [15:0] lens[4]  = '{16'd1, 16'd2, 16'd1, 16'd1};
    bit          rej[4]   = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] bq[$];
    bit ok;
    int n0, e0;
    for (int t = 0; t < 4; t++) begin
      n0 = mon_addr_q.size();
      e0 = err_cnt;
      do_start(bases[t], lens[t]);
      total++;
      if ({busy, err} !== {1'b1, rej[t]}) begin
        bad++;
        $display("FAIL bounds%0d_t1 busy,err got=%b exp=1%b", t, {busy, err}, rej[t]);
      end
      if (!rej[t]) begin
        bq.delete();
        for (int k = 0; k < 4; k++) bq.push_back(8'($urandom));
        send_bytes(bq, 2, ok);
        wait_idle(ok);
        total++;
        if (mon_addr_q.size() - n0 !== 1) begin
          bad++;
          $display("FAIL bounds%0d_count got=%0d exp=1", t, mon_addr_q.size() - n0);
        end else begin
          total++;
          if ({mon_addr_q[n0], mon_data_q[n0]} !== {64'd1020, bq[0], bq[1], bq[2], bq[3]}) begin
            bad++;
            $display("FAIL bounds%0d_word got=%h@%0d exp=%h@1020", t, mon_data_q[n0],
                     mon_addr_q[n0], {bq[0], bq[1], bq[2], bq[3]});
          end
        end
      end else begin
        @(posedge clk); #1;
        total++;
        if ({busy, err} !== 2'b00) begin
          bad++;
          $display("FAIL bounds%0d_t2 busy,err got=%b exp=00", t, {busy, err});
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (mon_addr_q.size() - n0 !== 0) begin
          bad++;
          $display("FAIL bounds%0d_nowrite got=%0d exp=0", t, mon_addr_q.size() - n0);
        end
      end
      total++;
      if (err_cnt - e0 !== int'(rej[t])) begin
        bad++;
        $display("FAIL bounds%0d_errcnt got=%0d exp=%0d", t, err_cnt - e0, rej[t]);
      end
    end
  endtask

  task automatic test_zero_and_ignored();
    logic [7:0] bq[$];
    bit ok;
    int n0, r0, d0;
    n0 = mon_addr_q.size();
    r0 = ir_cnt;
    do_start(64'h40, 16'd0);
    total++;
    if ({busy, err, done, in_ready} !== 4'b1010) begin
      bad++;
      $display("FAIL zero_t1 busy,err,done,ready got=%b exp=1010", {busy, err, done, in_ready});
    end
    @(posedge clk); #1;
    total++;
    if ({busy, done} !== 2'b00) begin bad++; $display("FAIL zero_t2 busy,done got=%b exp=00", {busy, done}); end
    total++;
    if ((mon_addr_q.size() - n0 !== 0) || (ir_cnt - r0 !== 0)) begin
      bad++;
      $display("FAIL zero_activity writes=%0d ready=%0d exp=0,0", mon_addr_q.size() - n0, ir_cnt - r0);
    end

    // A second start in LOAD must not change base or length
    n0 = mon_addr_q.size();
    d0 = done_cnt;
    bq = '{8'hA1, 8'hB2};
    do_start(64'h80, 16'd1);
    send_bytes(bq, 0, ok);
    do_start(64'h100, 16'd3);
    bq = '{8'hC3, 8'hD4};
    send_bytes(bq, 0, ok);
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ignored idle timeout got=0 exp=1"); end
    total++;
    if ((mon_addr_q.size() - n0 !== 1) || (done_cnt - d0 !== 1)) begin
      bad++;
      $display("FAIL ignored_count writes=%0d dones=%0d exp=1,1", mon_addr_q.size() - n0, done_cnt - d0);
    end else begin
      total++;
      if ({mon_addr_q[n0], mon_data_q[n0]} !== {64'h80, 32'hA1B2C3D4}) begin
        bad++;
        $display("FAIL ignored_word got=%h@%h exp=a1b2c3d4@80", mon_data_q[n0], mon_addr_q[n0]);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] b;
    int l;
    logic [7:0] bq[$];
    logic [63:0] ea[$];
    logic [31:0] ed[$];
    bit legal, ok;
    int n0, d0, e0, nw;
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 3))
        0: begin b = 64'($urandom_range(0, DEPTH - 1)) & ~64'd3; l = $urandom_range(0, 4); end
        1: begin b = 64'(DEPTH - 4 * $urandom_range(0, 5)); l = $urandom_range(1, 4); end
        2: begin b = 64'($urandom_range(0, 255) * 4 + $urandom_range(1, 3)); l = $urandom_range(1, 3); end
        default: begin b = {$urandom, $urandom} & ~64'd3; l = $urandom_range(1, 4); end
      endcase
      bq.delete();
      for (int k = 0; k < 4 * l; k++) bq.push_back(8'($urandom));
      model(b, l, bq, legal, ea, ed);
      n0 = mon_addr_q.size();
      d0 = done_cnt;
      e0 = err_cnt;
      do_start(b, 16'(l));
      if (legal && l > 0) send_bytes(bq, 2, ok);
      wait_idle(ok);
      repeat (2) @(posedge clk);
      #1;
      nw = mon_addr_q.size() - n0;
      total++;
      if ((nw !== ea.size()) || (done_cnt - d0 !== int'(legal)) || (err_cnt - e0 !== int'(!legal))) begin
        bad++;
        $display("FAIL rand%0d_summary base=%h len=%0d writes=%0d/%0d done=%0d err=%0d exp_legal=%0d",
                 it, b, l, nw, ea.size(), done_cnt - d0, err_cnt - e0, legal);
      end else begin
        for (int w = 0; w < nw; w++) begin
          total++;
          if ({mon_addr_q[n0+w], mon_data_q[n0+w]} !== {ea[w], ed[w]}) begin
            bad++;
            $display("FAIL rand%0d_word%0d got=%h@%h exp=%h@%h", it, w, mon_data_q[n0+w],
                     mon_addr_q[n0+w], ed[w], ea[w]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_bounds();
    test_zero_and_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader: the write side of the byte-addressed instruction memory that the fetch path reads as big-endian 32-bit words. It accepts a byte stream over a valid/ready handshake and packs each four bytes into one word, most significant byte first. Each finished word is written through a single-cycle write port at consecutive word addresses starting from a programmed base. It sits between the boot/debug byte source and the instruction memory, and owns the memory only while `busy` is high.

## Interface
- `DEPTH_BYTES`, 1024: size of the target memory in bytes; the legal range is `[0, DEPTH_BYTES)`.
- `LEN_W`, 16: width of the word-count input.
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: one-cycle request to begin a load; sampled only in IDLE.
- `base_addr`  in  64: byte address of the first word; latched on an accepted `start`.
- `len_words`  in  LEN_W: number of 32-bit words to load; latched on an accepted `start`.
- `in_byte`  in  8: stream data byte.
- `in_valid`  in  1: `in_byte` is valid.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `wr_en`  out  1: memory write strobe, one cycle per word.
- `wr_addr`  out  64: byte address of the word being written; always 4-aligned.
- `wr_data`  out  32: word being written; byte 0 of the group is `wr_data[31:24]`.
- `busy`  out  1: high from the cycle after an accepted `start` until the end of DONE or ERR.
- `done`  out  1: one-cycle pulse when the load completes.
- `err`  out  1: one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, LOAD, WRITE, DONE, ERR.
- **IDLE**
  - `start` = 1 latches `base_addr` and `len_words`, and clears the word index and byte count.
  - The request is illegal if `base_addr[1:0]` != 0, or if `base_addr + 4*len_words > DEPTH_BYTES`.
  - The bound check is computed at 66 bits, so it never wraps.
  - Illegal request -> ERR. Legal request with `len_words` = 0 -> DONE. Otherwise -> LOAD.
- **LOAD**
  - `in_ready` = 1.
  - Each handshake (`in_valid & in_ready`) shifts the byte into a 32-bit assembly register: `word <= {word[23:0], in_byte}`. Byte count increments mod 4.
  - The handshake that carries the 4th byte of a word -> WRITE.
- **WRITE** (exactly one cycle)
  - `wr_en` = 1, `wr_addr` = `base + 4*idx`, `wr_data` = assembled word, `in_ready` = 0.
  - If `idx + 1 == len`, go to DONE. Otherwise increment `idx` and go to LOAD.
- **DONE**: `done` = 1 for one cycle -> IDLE.
- **ERR**: `err` = 1 for one cycle -> IDLE. No write is ever issued on a rejected request.
- `start` in any state other than IDLE is ignored; it is not queued.
- Bytes offered while not in LOAD are not consumed, because `in_ready` = 0.
- `wr_addr` and `wr_data` are don't-care when `wr_en` = 0, but they must be held stable (registered).

## Timing
- Reset values: state IDLE; `in_ready`, `wr_en`, `busy`, `done`, `err` = 0; `wr_addr`, `wr_data`, and all internal counters and registers = 0.
- Reset asserted mid-load:
  - takes effect immediately (asynchronous);
  - the partial word is discarded, with no write;
  - the loader restarts only on a new `start` after reset is released.
- All outputs are registered, or decoded directly from the state register; there is no combinational path from `in_valid` to `in_ready`.
- Cycle-level sequence for a legal request:
  - `start` accepted at edge T: `busy` and `in_ready` are high from cycle T+1.
  - With the 4th byte of a word accepted at edge E: `wr_en` is high in cycle E+1, and `in_ready` is high again in E+2.
  - Peak throughput is 4 bytes per 5 cycles.
  - After the final WRITE cycle, `done` is high in the next cycle with `busy` still high. Both are low the cycle after, and `start` is accepted again that cycle.
- Rejected request: `err` = 1 and `busy` = 1 in cycle T+1; both are 0 in T+2.
- Gaps in `in_valid` stall LOAD indefinitely without losing the partial word.

## Test plan
- Reset mid-load:
  - Stimulus: `start`, base=0, len=2; send 6 bytes; assert `reset_n` = 0 for one cycle.
  - Required response: exactly one write seen before reset; all outputs 0 during reset.
  - After reset and a new `start`, base=0, len=1, bytes 11 22 33 44: the only write is 0x11223344 @ 0.
- Basic load:
  - Stimulus: base=0x10, len=2, bytes DE AD BE EF 01 02 03 04 streamed back-to-back.
  - Required response: writes 0xDEADBEEF @ 0x10 and 0x01020304 @ 0x14; one `done` pulse; `in_ready` = 0 in each WRITE cycle.
- Stalled stream:
  - Stimulus: base=0, len=1, `in_valid` toggling 1/0 each cycle with bytes 11 22 33 44.
  - Required response: a single write of 0x11223344 @ 0; no bytes lost or duplicated.
- Bounds:
  - base=1020, len=1: accepted; write @ 1020.
  - base=1020, len=2: `err` pulse, no `wr_en`.
  - base=0x2, len=1: `err` pulse.
  - base=0xFFFF_FFFF_FFFF_FFFC, len=1: `err` pulse (no wrap).
- Zero length and ignored start:
  - len=0: `done` in T+1, no writes, `in_ready` never high.
  - Second `start` issued during LOAD: ignored; the latched length is unchanged.
